task_answer_packetizer: RTL and testbench

TASK_ANSWER_PACKETIZER -- requirements
Module: task_answer_packetizer

---
 rtl/task_answer_packetizer.sv | 198 +++++++++++++++++++
 tb/tb_task_answer_packetizer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_answer_packetizer.sv
// task_answer_packetizer
//   Buffers answer words into an internal RAM, then streams them out as one
//   AXI-Stream style packet with o_tlast on the final word.
//
//   A packet ends either when the stored count reaches the latched target
//   (i_pkt_words, with 0 or values above DEPTH meaning DEPTH) or when a beat
//   carries i_input_last.
//
//   Optional feature: define TASK_OUT_OVERFLOW_CNT_EN to add o_overflow_cnt,
//   a saturating count of input beats dropped while a packet is being sent.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_pkt_words               packet length in words, sampled on first beat
//   i_data/i_data_valid       input word and its qualifier
//   i_input_last              marks the final word of a short packet
//   o_in_ready                high while input beats are accepted (IDLE, LOAD)
//   o_tdata/o_tvalid/o_tlast  output stream, i_tready is downstream ready
//   o_busy                    packet in progress (LOAD or SEND)
//   o_full                    stored count equals the latched target
//   o_packet_size_in_bytes    packet size while sending, 0 otherwise
//   o_overflow_cnt            (TASK_OUT_OVERFLOW_CNT_EN only) dropped beats
module task_answer_packetizer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [CNT_W-1:0]      i_pkt_words,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_input_last,
    output logic                  o_in_ready,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_tlast,
    output logic                  o_busy,
    output logic                  o_full,
    output logic [15:0]           o_packet_size_in_bytes
`ifdef TASK_OUT_OVERFLOW_CNT_EN
    ,
    output logic [15:0]           o_overflow_cnt
`endif
);

    localparam int PTR_W          = $clog2(DEPTH);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      target_q, target_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;   // words loaded into the output register
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  beat;
    logic                  fire;
    logic                  we;
    logic [CNT_W-1:0]      req_target;
    logic [CNT_W-1:0]      count_inc;

    always_comb begin
        beat       = i_data_valid && (state_q != SEND);
        fire       = tvalid_q && i_tready;
        // 0 and oversize requests both mean "fill the whole buffer"
        req_target = ((i_pkt_words == '0) || (i_pkt_words > CNT_W'(DEPTH)))
                     ? CNT_W'(DEPTH) : i_pkt_words;
        count_inc  = count_q + CNT_W'(1);

        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        target_d = target_q;
        rd_cnt_d = rd_cnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = CNT_W'(1);
                    target_d = req_target;
                    state_d  = ((req_target == CNT_W'(1)) || i_input_last) ? SEND : LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_inc;
                    if ((count_inc == target_q) || i_input_last) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (fire && tlast_q) begin
                    state_d  = IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    count_d  = '0;
                    target_d = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    rd_cnt_d = '0;
                end else if (!tvalid_q || fire) begin
                    // Refill the output register on entry and on every transfer,
                    // which keeps the stream bubble-free under constant ready.
                    tdata_d  = mem[rd_ptr_q];
                    tvalid_d = 1'b1;
                    tlast_d  = ((rd_cnt_q + CNT_W'(1)) == count_q);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            target_q <= '0;
            rd_cnt_q <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            target_q <= target_d;
            rd_cnt_q <= rd_cnt_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    // Data path: buffer RAM and output word register carry no reset.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[wr_ptr_q] <= i_data;
        end
        tdata_q <= tdata_d;
    end

    assign o_in_ready             = (state_q != SEND);
    assign o_busy                 = (state_q != IDLE);
    assign o_full                 = o_busy && (count_q == target_q);
    assign o_tdata                = tdata_q;
    assign o_tvalid               = tvalid_q;
    assign o_tlast                = tlast_q;
    assign o_packet_size_in_bytes = (state_q == SEND)
                                    ? 16'(count_q) * 16'(BYTES_PER_WORD) : 16'd0;

`ifdef TASK_OUT_OVERFLOW_CNT_EN
    logic [15:0] overflow_cnt_q, overflow_cnt_d;

    always_comb begin
        overflow_cnt_d = overflow_cnt_q;
        if ((state_q == SEND) && i_data_valid && (overflow_cnt_q != 16'hFFFF)) begin
            overflow_cnt_d = overflow_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_cnt_q <= '0;
        end else begin
            overflow_cnt_q <= overflow_cnt_d;
        end
    end

    assign o_overflow_cnt = overflow_cnt_q;
`endif

endmodule

// File: tb/tb_task_answer_packetizer.sv
module tb_task_answer_packetizer;

    localparam int DW    = 8;
    localparam int DEPTH = 128;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] i_pkt_words;
    logic [DW-1:0] i_data;
    logic          i_data_valid;
    logic          i_input_last;
    logic          o_in_ready;
    logic [DW-1:0] o_tdata;
    logic          o_tvalid;
    logic          i_tready;
    logic          o_tlast;
    logic          o_busy;
    logic          o_full;
    logic [15:0]   o_packet_size_in_bytes;
`ifdef TASK_OUT_OVERFLOW_CNT_EN
    logic [15:0]   o_overflow_cnt;
`endif

    always #5 clk = ~clk;

    task_answer_packetizer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_pkt_words            (i_pkt_words),
        .i_data                 (i_data),
        .i_data_valid           (i_data_valid),
        .i_input_last           (i_input_last),
        .o_in_ready             (o_in_ready),
        .o_tdata                (o_tdata),
        .o_tvalid               (o_tvalid),
        .i_tready               (i_tready),
        .o_tlast                (o_tlast),
        .o_busy                 (o_busy),
        .o_full                 (o_full),
        .o_packet_size_in_bytes (o_packet_size_in_bytes)
`ifdef TASK_OUT_OVERFLOW_CNT_EN
        ,
        .o_overflow_cnt         (o_overflow_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: {expected tlast, expected data}
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            stall_changes;
    int            size_first;
    bit            size_changed;
    bit            timeout;

    // Stimulus: one input beat, starting just after a rising edge.
    task automatic drive_beat(input logic [DW-1:0] d, input logic last);
        i_data       = d;
        i_data_valid = 1'b1;
        i_input_last = last;
        @(posedge clk); #1;
        i_data_valid = 1'b0;
        i_input_last = 1'b0;
    endtask

    // Drain the output stream with a repeating 4-cycle ready pattern and
    // record every transferred word; stops at tlast or after max_words.
    task automatic collect(input int max_words, input logic [3:0] pat);
        int          n = 0;
        int          cyc = 0;
        bit          prev_stall = 0;
        bit          first = 1;
        logic [DW-1:0] pd = '0;
        logic        pl = 1'b0;
        got_d.delete(); got_l.delete();
        stall_changes = 0; size_changed = 0; timeout = 0; size_first = 0;
        while (1) begin
            i_tready = pat[cyc % 4];
            @(negedge clk);
            if (o_tvalid) begin
                if (first) begin
                    size_first = int'(o_packet_size_in_bytes);
                    first = 0;
                end else if (int'(o_packet_size_in_bytes) != size_first) begin
                    size_changed = 1;
                end
            end
            if (prev_stall && (o_tvalid !== 1'b1 || o_tdata !== pd || o_tlast !== pl))
                stall_changes++;
            prev_stall = o_tvalid && !i_tready;
            pd = o_tdata;
            pl = o_tlast;
            if (o_tvalid && i_tready) begin
                got_d.push_back(o_tdata);
                got_l.push_back(o_tlast);
                n++;
            end
            @(posedge clk); #1;
            cyc++;
            if ((n > 0 && got_l[n-1]) || n >= max_words) break;
            if (cyc > 2000) begin
                timeout = 1;
                break;
            end
        end
        i_tready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_tvalid, o_tlast, o_busy, o_full} !== 4'b0000 || o_packet_size_in_bytes !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs got tvalid/tlast/busy/full=%b size=%0d want 0000 size=0",
                     {o_tvalid, o_tlast, o_busy, o_full}, o_packet_size_in_bytes);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b want 1", o_in_ready);
        end
`ifdef TASK_OUT_OVERFLOW_CNT_EN
        checks++;
        if (o_overflow_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_overflow got %0d want 0", o_overflow_cnt);
        end
`endif
    endtask

    task automatic test_full_81();
        i_pkt_words = CW'(81);
        for (int i = 0; i < 81; i++) begin
            exp_q.push_back({(i == 80), DW'(i)});
            drive_beat(DW'(i), 1'b0);
        end
        collect(1000, 4'b1111);
        checks++;
        if (timeout || got_d.size() != 81) begin
            failures++;
            $display("FAIL full81_count got %0d words want 81 (timeout=%0d)", got_d.size(), timeout);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            logic [DW:0] e = exp_q.pop_front();
            checks++;
            if ({got_l[i], got_d[i]} !== e) begin
                failures++;
                $display("FAIL full81_word%0d got last=%b data=%0d want last=%b data=%0d",
                         i, got_l[i], got_d[i], e[DW], e[DW-1:0]);
            end
        end
        exp_q.delete();
        checks++;
        if (size_first != 81 || size_changed) begin
            failures++;
            $display("FAIL full81_size got %0d changed=%0d want 81 constant", size_first, size_changed);
        end
        checks++;
        if (o_busy !== 1'b0 || o_packet_size_in_bytes !== 16'd0) begin
            failures++;
            $display("FAIL full81_idle got busy=%b size=%0d want 0 0", o_busy, o_packet_size_in_bytes);
        end
    endtask

    task automatic test_input_last();
        i_pkt_words = CW'(81);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({(i == 4), DW'(8'h40 + i)});
            drive_beat(DW'(8'h40 + i), (i == 4));
            if (i == 1) begin
                // a lone i_input_last without valid must not end the packet
                i_input_last = 1'b1;
                @(posedge clk); #1;
                i_input_last = 1'b0;
            end
        end
        collect(1000, 4'b1111);
        checks++;
        if (timeout || got_d.size() != 5) begin
            failures++;
            $display("FAIL last5_count got %0d words want 5 (timeout=%0d)", got_d.size(), timeout);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            logic [DW:0] e = exp_q.pop_front();
            checks++;
            if ({got_l[i], got_d[i]} !== e) begin
                failures++;
                $display("FAIL last5_word%0d got last=%b data=%0d want last=%b data=%0d",
                         i, got_l[i], got_d[i], e[DW], e[DW-1:0]);
            end
        end
        exp_q.delete();
        checks++;
        if (size_first != 5) begin
            failures++;
            $display("FAIL last5_size got %0d want 5", size_first);
        end
    endtask

    task automatic test_stall();
        i_pkt_words = CW'(9);
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({(i == 8), DW'(8'hA0 + i)});
            drive_beat(DW'(8'hA0 + i), 1'b0);
        end
        collect(1000, 4'b1001);   // ready 1,0,0,1 repeating
        checks++;
        if (timeout || got_d.size() != 9) begin
            failures++;
            $display("FAIL stall_count got %0d words want 9 (timeout=%0d)", got_d.size(), timeout);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            logic [DW:0] e = exp_q.pop_front();
            checks++;
            if ({got_l[i], got_d[i]} !== e) begin
                failures++;
                $display("FAIL stall_word%0d got last=%b data=%0d want last=%b data=%0d",
                         i, got_l[i], got_d[i], e[DW], e[DW-1:0]);
            end
        end
        exp_q.delete();
        checks++;
        if (stall_changes != 0) begin
            failures++;
            $display("FAIL stall_hold got %0d output changes while stalled want 0", stall_changes);
        end
    endtask

    task automatic test_depth_clamp();
        i_pkt_words = '0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back({(i == DEPTH - 1), DW'(i)});
            drive_beat(DW'(i), 1'b0);
            if (i == DEPTH - 2) begin
                checks++;
                if (o_full !== 1'b0 || o_in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL clamp_not_full got full=%b ready=%b want 0 1", o_full, o_in_ready);
                end
            end
        end
        checks++;
        if (o_full !== 1'b1 || o_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL clamp_full got full=%b ready=%b want 1 0", o_full, o_in_ready);
        end
        collect(1000, 4'b1111);
        checks++;
        if (timeout || got_d.size() != DEPTH) begin
            failures++;
            $display("FAIL clamp_count got %0d words want %0d (timeout=%0d)", got_d.size(), DEPTH, timeout);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            logic [DW:0] e = exp_q.pop_front();
            checks++;
            if ({got_l[i], got_d[i]} !== e) begin
                failures++;
                $display("FAIL clamp_word%0d got last=%b data=%0d want last=%b data=%0d",
                         i, got_l[i], got_d[i], e[DW], e[DW-1:0]);
            end
        end
        exp_q.delete();
        checks++;
        if (size_first != DEPTH) begin
            failures++;
            $display("FAIL clamp_size got %0d want %0d", size_first, DEPTH);
        end
    endtask

    task automatic test_single_word();
        i_pkt_words = CW'(1);
        exp_q.push_back({1'b1, 8'h5A});
        drive_beat(8'h5A, 1'b0);
        checks++;
        if (o_in_ready !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL single_send got ready=%b busy=%b want 0 1", o_in_ready, o_busy);
        end
        collect(1000, 4'b1111);
        checks++;
        if (timeout || got_d.size() != 1 || {got_l[0], got_d[0]} !== exp_q[0]) begin
            failures++;
            $display("FAIL single_word got %0d words first=%0h want 1 word last=1 data=5a",
                     got_d.size(), (got_d.size() > 0) ? got_d[0] : 8'h00);
        end
        exp_q.delete();
    endtask

    task automatic test_drop_in_send();
        i_pkt_words = CW'(20);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({(i == 3), DW'(8'h10 + i)});
            drive_beat(DW'(8'h10 + i), (i == 3));
        end
        for (int i = 0; i < 3; i++) drive_beat(8'hEE, 1'b1);
        checks++;
        if (o_busy !== 1'b1 || o_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL drop_state got busy=%b ready=%b want 1 0", o_busy, o_in_ready);
        end
        collect(1000, 4'b1111);
        checks++;
        if (timeout || got_d.size() != 4) begin
            failures++;
            $display("FAIL drop_count got %0d words want 4 (timeout=%0d)", got_d.size(), timeout);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            logic [DW:0] e = exp_q.pop_front();
            checks++;
            if ({got_l[i], got_d[i]} !== e) begin
                failures++;
                $display("FAIL drop_word%0d got last=%b data=%0d want last=%b data=%0d",
                         i, got_l[i], got_d[i], e[DW], e[DW-1:0]);
            end
        end
        exp_q.delete();
`ifdef TASK_OUT_OVERFLOW_CNT_EN
        checks++;
        if (o_overflow_cnt !== 16'd3) begin
            failures++;
            $display("FAIL drop_overflow got %0d want 3", o_overflow_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_send();
        i_pkt_words = CW'(64);
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back({(i == 63), DW'(8'hC0 + i)});
            drive_beat(DW'(8'hC0 + i), 1'b0);
        end
        collect(40, 4'b1111);
        checks++;
        if (timeout || got_d.size() != 40 || o_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_prefix got %0d words tvalid=%b want 40 1", got_d.size(), o_tvalid);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            logic [DW:0] e = exp_q.pop_front();
            checks++;
            if ({got_l[i], got_d[i]} !== e) begin
                failures++;
                $display("FAIL rstmid_word%0d got last=%b data=%0d want last=%b data=%0d",
                         i, got_l[i], got_d[i], e[DW], e[DW-1:0]);
            end
        end
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_tvalid, o_tlast, o_busy, o_full} !== 4'b0000 || o_packet_size_in_bytes !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_async got tvalid/tlast/busy/full=%b size=%0d want 0000 size=0",
                     {o_tvalid, o_tlast, o_busy, o_full}, o_packet_size_in_bytes);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ready got %b want 1", o_in_ready);
        end
        i_pkt_words = CW'(10);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({(i == 9), DW'(8'h70 + i)});
            drive_beat(DW'(8'h70 + i), 1'b0);
        end
        collect(1000, 4'b1111);
        checks++;
        if (timeout || got_d.size() != 10) begin
            failures++;
            $display("FAIL rstmid_next_count got %0d words want 10 (timeout=%0d)", got_d.size(), timeout);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            logic [DW:0] e = exp_q.pop_front();
            checks++;
            if ({got_l[i], got_d[i]} !== e) begin
                failures++;
                $display("FAIL rstmid_next_word%0d got last=%b data=%0d want last=%b data=%0d",
                         i, got_l[i], got_d[i], e[DW], e[DW-1:0]);
            end
        end
        exp_q.delete();
        checks++;
        if (size_first != 10) begin
            failures++;
            $display("FAIL rstmid_next_size got %0d want 10", size_first);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        i_pkt_words  = '0;
        i_data       = '0;
        i_data_valid = 1'b0;
        i_input_last = 1'b0;
        i_tready     = 1'b0;
        test_reset();
        test_full_81();
        test_input_last();
        test_stall();
        test_depth_clamp();
        test_single_word();
        test_drop_in_send();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
